// File: rtl/serial_chunk_adder_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encodings
// and a clog2 helper used to size index counters.
package serial_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Never returns less than 1 so a single-chunk design still gets a counter bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  always_comb begin : ripple
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock with the
// carry held in a register between cycles; start/done handshake.
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = clog2_min1(NCHUNK);
  localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  state_t           state, next_state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_r, b_r, s_r;
  logic             carry, cout_r, ovf_r;
  logic             load, step, last;
  logic [31:0]      base;
  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             chunk_co;

  assign base    = 32'(idx) * 32'(CHUNK);
  assign a_chunk = CHUNK'(a_r >> base);
  assign b_chunk = CHUNK'(b_r >> base);

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (a_chunk),
    .b  (b_chunk),
    .ci (carry),
    .s  (sum_chunk),
    .co (chunk_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (idx == LAST_IDX) next_state = ST_DONE;
      ST_DONE: next_state = start ? ST_RUN : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // DONE accepts a new start just like IDLE, allowing back-to-back operations.
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
    step = (state == ST_RUN);
    load = start && ((state == ST_IDLE) || (state == ST_DONE));
    last = step && (idx == LAST_IDX);
  end

  // Subtraction is a + ~b + 1: B is inverted at load and the carry seeded to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      idx    <= '0;
    end else if (load) begin
      a_r   <= a;
      b_r   <= b ^ {WIDTH{sub}};
      carry <= sub ? 1'b1 : cin;
      idx   <= '0;
    end else if (step) begin
      s_r   <= (s_r & ~(CHUNK_MASK << base)) | (WIDTH'(sum_chunk) << base);
      carry <= chunk_co;
      if (last) begin
        cout_r <= chunk_co;
        ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                  (sum_chunk[CHUNK-1] != a_r[WIDTH-1]);
      end else begin
        idx <= idx + IDXW'(1);
      end
    end
  end

  assign s    = s_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule
